// File: rtl/mdio_phy_responder_if.sv
// -----------------------------------------------------------------------------
// mdio_phy_responder_if
//
// Bundles the MDIO pad signals and the local host/status port of the Clause-22
// MDIO PHY responder.
//
//   slave  modport : the responder (drives pad output, host read data, status)
//   master modport : the environment (drives MDC/MDIO pad input, host access)
//
// Signals:
//   mdc_i       MDIO clock from the station manager (async to the system clock)
//   mdio_i      MDIO pad input
//   mdio_o      MDIO pad output value
//   mdio_oe     MDIO pad output enable (1 = drive mdio_o, 0 = release)
//   host_we     host write strobe, one system clock cycle
//   host_addr   host register address (read and write)
//   host_wdata  host write data
//   host_rdata  registered read data, regfile[host_addr], 1-cycle latency
//   wr_strobe   one-cycle pulse when an MDIO write commits
//   wr_addr     register address of the last MDIO write
//   rd_strobe   one-cycle pulse when an MDIO read frame is accepted
//   busy        high from start-of-frame detection until frame end/abort
// -----------------------------------------------------------------------------
interface mdio_phy_responder_if;
  logic        mdc_i;
  logic        mdio_i;
  logic        mdio_o;
  logic        mdio_oe;
  logic        host_we;
  logic [4:0]  host_addr;
  logic [15:0] host_wdata;
  logic [15:0] host_rdata;
  logic        wr_strobe;
  logic [4:0]  wr_addr;
  logic        rd_strobe;
  logic        busy;

  modport slave (
    input  mdc_i, mdio_i, host_we, host_addr, host_wdata,
    output mdio_o, mdio_oe, host_rdata, wr_strobe, wr_addr, rd_strobe, busy
  );

  modport master (
    output mdc_i, mdio_i, host_we, host_addr, host_wdata,
    input  mdio_o, mdio_oe, host_rdata, wr_strobe, wr_addr, rd_strobe, busy
  );
endinterface

// File: rtl/mdio_phy_responder.sv
// -----------------------------------------------------------------------------
// mdio_phy_responder
//
// PHY-side Clause-22 MDIO endpoint. Oversamples MDC/MDIO with the system clock,
// decodes frames addressed to PHY_ADDR, serves reads from and commits writes
// to a 32 x 16-bit register file. A host port lets local logic preload and
// inspect the register file.
//
// Parameters:
//   PHY_ADDR  PHY address this responder answers to
//   PRE_MIN   consecutive preamble '1' bits required before start-of-frame
//
// Ports:
//   clk_i     system clock, at least 8x the MDC frequency
//   rst_i     asynchronous, active-high reset
//   bus       mdio_phy_responder_if.slave (MDIO pad + host/status signals)
//
// Timing: MDIO is sampled 3 clk_i cycles after an MDC rising edge at the pin
// (2 synchronizer flops + 1 edge-detect flop); the pad output changes 3 clk_i
// cycles after an MDC falling edge at the pin.
// -----------------------------------------------------------------------------
module mdio_phy_responder #(
  parameter logic [4:0] PHY_ADDR = 5'b00111,
  parameter int         PRE_MIN  = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  mdio_phy_responder_if.slave    bus
);

  // Preamble counter saturates at PRE_MIN, so it only needs to hold PRE_MIN.
  localparam int                 PRE_W   = (PRE_MIN < 1) ? 1 : $clog2(PRE_MIN + 1);
  localparam logic [PRE_W-1:0]   PRE_SAT = PRE_W'(PRE_MIN);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_ST    = 4'd1;
  localparam logic [3:0] S_OP    = 4'd2;
  localparam logic [3:0] S_PHYAD = 4'd3;
  localparam logic [3:0] S_REGAD = 4'd4;
  localparam logic [3:0] S_TA    = 4'd5;
  localparam logic [3:0] S_WDATA = 4'd6;
  localparam logic [3:0] S_RDATA = 4'd7;
  localparam logic [3:0] S_SKIP  = 4'd8;

  // ---------------------------------------------------------------------------
  // Synchronizers and MDC edge detection
  // ---------------------------------------------------------------------------
  logic [1:0] mdc_sync_q;
  logic [1:0] mdio_sync_q;
  logic       mdc_prev_q;
  logic       mdc_s;
  logic       mdio_s;
  logic       mdc_rise;
  logic       mdc_fall;

  assign mdc_s    = mdc_sync_q[1];
  assign mdio_s   = mdio_sync_q[1];
  assign mdc_rise = mdc_s & ~mdc_prev_q;
  assign mdc_fall = ~mdc_s & mdc_prev_q;

  // ---------------------------------------------------------------------------
  // Frame decoder state
  // ---------------------------------------------------------------------------
  logic [3:0]       state_q,     state_d;
  logic [PRE_W-1:0] pre_cnt_q,   pre_cnt_d;
  logic [4:0]       bit_cnt_q,   bit_cnt_d;
  logic             op_hi_q,     op_hi_d;
  logic             is_read_q,   is_read_d;
  logic [4:0]       phyad_q,     phyad_d;
  logic             phy_match_q, phy_match_d;
  logic [4:0]       regad_q,     regad_d;
  logic [15:0]      shift_q,     shift_d;
  logic [4:0]       fall_cnt_q,  fall_cnt_d;
  logic             commit_q,    commit_d;
  logic             busy_q,      busy_d;
  logic             mdio_o_q,    mdio_o_d;
  logic             mdio_oe_q,   mdio_oe_d;
  logic             wr_strobe_q, wr_strobe_d;
  logic             rd_strobe_q, rd_strobe_d;
  logic [4:0]       wr_addr_q,   wr_addr_d;
  logic             go_idle;

  logic [15:0]      regfile_q [32];
  logic [15:0]      host_rdata_q;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d     = state_q;
    pre_cnt_d   = pre_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    op_hi_d     = op_hi_q;
    is_read_d   = is_read_q;
    phyad_d     = phyad_q;
    phy_match_d = phy_match_q;
    regad_d     = regad_q;
    shift_d     = shift_q;
    fall_cnt_d  = fall_cnt_q;
    busy_d      = busy_q;
    mdio_o_d    = mdio_o_q;
    mdio_oe_d   = mdio_oe_q;
    wr_addr_d   = wr_addr_q;
    commit_d    = 1'b0;
    wr_strobe_d = 1'b0;
    rd_strobe_d = 1'b0;
    go_idle     = 1'b0;

    if (commit_q) begin
      // Cycle after the 16th write-data sample: the register file takes the
      // data on this same edge (see the register-file block).
      wr_strobe_d = 1'b1;
      wr_addr_d   = regad_q;
      go_idle     = 1'b1;
    end else if (mdc_rise) begin
      case (state_q)
        S_IDLE: begin
          if (mdio_s) begin
            if (pre_cnt_q < PRE_SAT) pre_cnt_d = pre_cnt_q + PRE_W'(1);
          end else if (pre_cnt_q >= PRE_SAT) begin
            // This 0 is the first start-of-frame bit.
            state_d   = S_ST;
            busy_d    = 1'b1;
            pre_cnt_d = '0;
          end else begin
            pre_cnt_d = '0;
          end
        end

        S_ST: begin
          if (mdio_s) begin
            state_d   = S_OP;
            bit_cnt_d = 5'd0;
          end else begin
            go_idle = 1'b1;
          end
        end

        S_OP: begin
          if (bit_cnt_q == 5'd0) begin
            op_hi_d   = mdio_s;
            bit_cnt_d = 5'd1;
          end else begin
            case ({op_hi_q, mdio_s})
              2'b01: begin
                is_read_d = 1'b0;
                state_d   = S_PHYAD;
                bit_cnt_d = 5'd0;
              end
              2'b10: begin
                is_read_d = 1'b1;
                state_d   = S_PHYAD;
                bit_cnt_d = 5'd0;
              end
              default: go_idle = 1'b1;
            endcase
          end
        end

        S_PHYAD: begin
          phyad_d = {phyad_q[3:0], mdio_s};
          if (bit_cnt_q == 5'd4) begin
            phy_match_d = (phyad_d == PHY_ADDR);
            state_d     = S_REGAD;
            bit_cnt_d   = 5'd0;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end

        S_REGAD: begin
          regad_d = {regad_q[3:0], mdio_s};
          if (bit_cnt_q == 5'd4) begin
            bit_cnt_d = 5'd0;
            if (!phy_match_q) begin
              // Another PHY owns this frame: stay off the pad for TA + data.
              state_d = S_SKIP;
            end else if (is_read_q) begin
              // Snapshot now so later host writes cannot alter the read data.
              state_d     = S_RDATA;
              shift_d     = regfile_q[regad_d];
              rd_strobe_d = 1'b1;
              fall_cnt_d  = 5'd0;
            end else begin
              state_d = S_TA;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end

        S_TA: begin
          if (bit_cnt_q == 5'd1) begin
            state_d   = S_WDATA;
            bit_cnt_d = 5'd0;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end

        S_WDATA: begin
          shift_d = {shift_q[14:0], mdio_s};
          if (bit_cnt_q == 5'd15) commit_d = 1'b1;
          else                    bit_cnt_d = bit_cnt_q + 5'd1;
        end

        S_SKIP: begin
          if (bit_cnt_q == 5'd17) go_idle = 1'b1;
          else                    bit_cnt_d = bit_cnt_q + 5'd1;
        end

        // The read frame is paced by falling edges; rising samples are unused.
        S_RDATA: ;

        default: go_idle = 1'b1;
      endcase
    end else if (mdc_fall && (state_q == S_RDATA)) begin
      // Falling edges after the last REGAD sample: 1 = TA Z, 2 = TA 0,
      // 3..18 = D15..D0, 19 = release and finish.
      fall_cnt_d = fall_cnt_q + 5'd1;
      if (fall_cnt_q == 5'd0) begin
        mdio_oe_d = 1'b0;
      end else if (fall_cnt_q == 5'd1) begin
        mdio_oe_d = 1'b1;
        mdio_o_d  = 1'b0;
      end else if (fall_cnt_q <= 5'd17) begin
        mdio_o_d = shift_q[15];
        shift_d  = {shift_q[14:0], 1'b0};
      end else begin
        mdio_oe_d = 1'b0;
        mdio_o_d  = 1'b1;
        go_idle   = 1'b1;
      end
    end

    // Every way back to IDLE restarts preamble detection and drops busy.
    if (go_idle) begin
      state_d   = S_IDLE;
      pre_cnt_d = '0;
      busy_d    = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: non-blocking assignments throughout, so every flop samples the
    // pre-edge value of every other flop regardless of statement order.
    if (rst_i) begin
      mdc_sync_q  <= 2'b00;
      mdio_sync_q <= 2'b11;
      mdc_prev_q  <= 1'b0;
      state_q     <= S_IDLE;
      pre_cnt_q   <= '0;
      bit_cnt_q   <= 5'd0;
      op_hi_q     <= 1'b0;
      is_read_q   <= 1'b0;
      phyad_q     <= 5'd0;
      phy_match_q <= 1'b0;
      regad_q     <= 5'd0;
      shift_q     <= 16'h0000;
      fall_cnt_q  <= 5'd0;
      commit_q    <= 1'b0;
      busy_q      <= 1'b0;
      mdio_o_q    <= 1'b1;
      mdio_oe_q   <= 1'b0;
      wr_strobe_q <= 1'b0;
      rd_strobe_q <= 1'b0;
      wr_addr_q   <= 5'd0;
    end else begin
      mdc_sync_q  <= {mdc_sync_q[0], bus.mdc_i};
      mdio_sync_q <= {mdio_sync_q[0], bus.mdio_i};
      mdc_prev_q  <= mdc_s;
      state_q     <= state_d;
      pre_cnt_q   <= pre_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      op_hi_q     <= op_hi_d;
      is_read_q   <= is_read_d;
      phyad_q     <= phyad_d;
      phy_match_q <= phy_match_d;
      regad_q     <= regad_d;
      shift_q     <= shift_d;
      fall_cnt_q  <= fall_cnt_d;
      commit_q    <= commit_d;
      busy_q      <= busy_d;
      mdio_o_q    <= mdio_o_d;
      mdio_oe_q   <= mdio_oe_d;
      wr_strobe_q <= wr_strobe_d;
      rd_strobe_q <= rd_strobe_d;
      wr_addr_q   <= wr_addr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Register file and host port
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      // NOTE: the register file is deliberately reset, so it is built from
      // flops rather than a RAM macro; reset must leave every entry at zero.
      for (int i = 0; i < 32; i++) regfile_q[i] <= 16'h0000;
      host_rdata_q <= 16'h0000;
    end else begin
      if (bus.host_we) regfile_q[bus.host_addr] <= bus.host_wdata;
      // Issued after the host write so the MDIO data wins an address clash.
      if (commit_q)    regfile_q[regad_q]       <= shift_q;
      host_rdata_q <= regfile_q[bus.host_addr];
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.mdio_o     = mdio_o_q;
  assign bus.mdio_oe    = mdio_oe_q;
  assign bus.host_rdata = host_rdata_q;
  assign bus.wr_strobe  = wr_strobe_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.rd_strobe  = rd_strobe_q;
  assign bus.busy       = busy_q;

endmodule
